estagio_busca: RTL and testbench

Instruction-fetch stage of the RISC-V core: owns the program counter, fetches 32-bit words from instruction memory over a request/acknowledge handshake, and presents each fetched instruction, with its PC, to decode through a valid/ready output register. Its `instr_saida` is the `instr` input consumed by `gerador_imm` and the rest of decode. Branch/jump redirects from execute flush the held instruction and discard any in-flight memory response.

---
 rtl/estagio_busca.sv | 137 +++++++++++++
 tb/tb_estagio_busca.sv | 444 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/estagio_busca.sv
`default_nettype none
// ============================================================================
// Module   : estagio_busca
// Function : RISC-V instruction-fetch stage. Owns the PC, fetches words from
//            instruction memory over a req/ack handshake and hands each
//            instruction (with its PC) to decode via a valid/ready register.
//            Redirects from execute flush the held instruction and discard
//            any in-flight memory response.
// Revision : 1.0 - initial release
// ============================================================================
module estagio_busca #(
  parameter int                    DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0] PC_RESET   = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic                  mem_req,
  output logic [DATA_WIDTH-1:0] mem_addr,
  input  logic                  mem_ack,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  input  logic                  desvio,
  input  logic [DATA_WIDTH-1:0] alvo_desvio,
  input  logic                  pronto_decod,
  output logic                  valid_saida,
  output logic [DATA_WIDTH-1:0] instr_saida,
  output logic [DATA_WIDTH-1:0] pc_instr
);

  localparam logic [1:0] INICIO   = 2'd0;
  localparam logic [1:0] BUSCA    = 2'd1;
  localparam logic [1:0] DESCARTA = 2'd2;
  localparam logic [1:0] ENTREGA  = 2'd3;

  // Reset PC with the low bits cleared so fetches are always word aligned.
  localparam logic [DATA_WIDTH-1:0] C_PC_INICIAL = {PC_RESET[DATA_WIDTH-1:2], 2'b00};

  logic [1:0]            state_q,   state_d;
  logic [DATA_WIDTH-1:0] pc_q,      pc_d;
  logic [DATA_WIDTH-1:0] pc_alvo_q, pc_alvo_d;
  logic [DATA_WIDTH-1:0] instr_q,   instr_d;
  logic [DATA_WIDTH-1:0] pc_instr_q, pc_instr_d;
  logic                  valid_q,   valid_d;

  logic [DATA_WIDTH-1:0] w_alvo_alinhado;
  logic                  w_unused_alvo_lsb;

  // Redirect targets are forced to a word boundary; the dropped bits are unused.
  assign w_alvo_alinhado   = {alvo_desvio[DATA_WIDTH-1:2], 2'b00};
  assign w_unused_alvo_lsb = ^alvo_desvio[1:0];

  // Next-state / datapath decision for the fetch FSM.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    pc_alvo_d  = pc_alvo_q;
    instr_d    = instr_q;
    pc_instr_d = pc_instr_q;

    case (state_q)
      INICIO: begin
        state_d = BUSCA;
      end

      BUSCA: begin
        if (mem_ack) begin
          if (desvio) begin
            // Response belongs to the wrong path: drop it, refetch at target.
            pc_d = w_alvo_alinhado;
          end else begin
            instr_d    = mem_rdata;
            pc_instr_d = pc_q;
            pc_d       = pc_q + DATA_WIDTH'(4);
            state_d    = ENTREGA;
          end
        end else if (desvio) begin
          // Request cannot be withdrawn; remember target and wait for the ack.
          pc_alvo_d = w_alvo_alinhado;
          state_d   = DESCARTA;
        end
      end

      DESCARTA: begin
        if (mem_ack) begin
          // Latest redirect wins, including one arriving with the ack.
          pc_d    = desvio ? w_alvo_alinhado : pc_alvo_q;
          state_d = BUSCA;
        end else if (desvio) begin
          pc_alvo_d = w_alvo_alinhado;
        end
      end

      ENTREGA: begin
        if (desvio) begin
          // Flush has priority over consumption.
          pc_d    = w_alvo_alinhado;
          state_d = BUSCA;
        end else if (pronto_decod) begin
          state_d = BUSCA;
        end
      end

      default: begin
        state_d = INICIO;
      end
    endcase

    valid_d = (state_d == ENTREGA);
  end

  // State and output registers, asynchronously reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= INICIO;
      pc_q       <= C_PC_INICIAL;
      pc_alvo_q  <= '0;
      instr_q    <= '0;
      pc_instr_q <= '0;
      valid_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      pc_alvo_q  <= pc_alvo_d;
      instr_q    <= instr_d;
      pc_instr_q <= pc_instr_d;
      valid_q    <= valid_d;
    end
  end

  // Memory request is decoded purely from state and PC.
  assign mem_req     = (state_q == BUSCA) || (state_q == DESCARTA);
  assign mem_addr    = pc_q;
  assign valid_saida = valid_q;
  assign instr_saida = instr_q;
  assign pc_instr    = pc_instr_q;

endmodule
`default_nettype wire

// File: tb/tb_estagio_busca.sv
`default_nettype none
// ============================================================================
// Module   : tb_estagio_busca
// Function : Self-checking bench for estagio_busca. A memory model answers
//            requests after a configurable number of wait cycles; delivered
//            instructions are predicted into a scoreboard queue and compared
//            when decode sees them.
// Revision : 1.0 - initial release
// ============================================================================
module tb_estagio_busca;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } sb_t;

  logic        clk;
  logic        rst;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        desvio;
  logic [31:0] alvo_desvio;
  logic        pronto_decod;
  logic        valid_saida;
  logic [31:0] instr_saida;
  logic [31:0] pc_instr;

  // Second instance: wrap-around reset PC with an always-ready zero-wait memory.
  logic        w_mem_req;
  logic [31:0] w_mem_addr;
  logic        w_valid;
  logic [31:0] w_instr;
  logic [31:0] w_pc_instr;

  int   n_checks;
  int   n_errors;
  sb_t  sb_q[$];
  sb_t  exp_e;

  logic        drv_desvio;
  logic [31:0] drv_alvo;
  logic        drv_pronto;
  int          mem_wait;
  logic        req_act;
  logic [31:0] req_addr;
  int          wcnt;
  logic        poison;

  estagio_busca #(.DATA_WIDTH(32), .PC_RESET(32'h0000_0000)) u_dut (
    .clk          (clk),
    .rst          (rst),
    .mem_req      (mem_req),
    .mem_addr     (mem_addr),
    .mem_ack      (mem_ack),
    .mem_rdata    (mem_rdata),
    .desvio       (desvio),
    .alvo_desvio  (alvo_desvio),
    .pronto_decod (pronto_decod),
    .valid_saida  (valid_saida),
    .instr_saida  (instr_saida),
    .pc_instr     (pc_instr)
  );

  estagio_busca #(.DATA_WIDTH(32), .PC_RESET(32'hFFFF_FFFC)) u_wrap (
    .clk          (clk),
    .rst          (rst),
    .mem_req      (w_mem_req),
    .mem_addr     (w_mem_addr),
    .mem_ack      (w_mem_req),
    .mem_rdata    (32'h0000_0013),
    .desvio       (1'b0),
    .alvo_desvio  (32'h0000_0000),
    .pronto_decod (1'b1),
    .valid_saida  (w_valid),
    .instr_saida  (w_instr),
    .pc_instr     (w_pc_instr)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a << 12) | 32'h0000_2083;
  endfunction

  // One clock cycle: apply drives at the falling edge, run the memory model,
  // and check whatever decode sees against the scoreboard.
  task automatic cycle();
    @(negedge clk);
    desvio       = drv_desvio;
    alvo_desvio  = drv_alvo;
    pronto_decod = drv_pronto;
    if (mem_req) begin
      if (!req_act) begin
        req_act  = 1'b1;
        req_addr = mem_addr;
        wcnt     = 0;
        poison   = 1'b0;
      end else begin
        n_checks++;
        if (mem_addr !== req_addr) begin
          n_errors++;
          $display("FAIL mem_addr_stable: got %h required %h", mem_addr, req_addr);
        end
      end
      if (desvio) poison = 1'b1;
      if (wcnt == mem_wait) begin
        mem_ack   = 1'b1;
        mem_rdata = mem_word(req_addr);
        if (!poison) sb_q.push_back('{pc: req_addr, instr: mem_word(req_addr)});
        req_act   = 1'b0;
      end else begin
        mem_ack   = 1'b0;
        mem_rdata = 32'h0BAD_0BAD;
        wcnt++;
      end
    end else begin
      // Stray ack with junk data; must be ignored while no request is open.
      req_act   = 1'b0;
      mem_ack   = 1'b1;
      mem_rdata = 32'hDEAD_BEEF;
    end
    if (valid_saida) begin
      n_checks++;
      if (sb_q.size() == 0) begin
        n_errors++;
        $display("FAIL sb_unexpected: got pc %h instr %h required none", pc_instr, instr_saida);
      end else begin
        exp_e = sb_q[0];
        if (pc_instr !== exp_e.pc || instr_saida !== exp_e.instr) begin
          n_errors++;
          $display("FAIL sb_output: got pc %h instr %h required pc %h instr %h",
                   pc_instr, instr_saida, exp_e.pc, exp_e.instr);
        end
        if (desvio || pronto_decod) void'(sb_q.pop_front());
      end
    end
  endtask

  task automatic do_reset();
    rst          = 1'b1;
    drv_desvio   = 1'b0;
    drv_alvo     = '0;
    drv_pronto   = 1'b1;
    desvio       = 1'b0;
    alvo_desvio  = '0;
    pronto_decod = 1'b1;
    mem_ack      = 1'b0;
    mem_rdata    = '0;
    sb_q.delete();
    req_act      = 1'b0;
    repeat (2) @(negedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #3;
    n_checks++;
    if (mem_req !== 1'b0 || valid_saida !== 1'b0 || instr_saida !== 32'h0 || pc_instr !== 32'h0) begin
      n_errors++;
      $display("FAIL reset_hold: got req %b valid %b instr %h pc %h required 0 0 0 0",
               mem_req, valid_saida, instr_saida, pc_instr);
    end
    mem_wait = 0;
    do_reset();
    cycle();
    n_checks++;
    if (mem_req !== 1'b0 || valid_saida !== 1'b0) begin
      n_errors++;
      $display("FAIL reset_c0: got req %b valid %b required 0 0", mem_req, valid_saida);
    end
    cycle();
    n_checks++;
    if (mem_req !== 1'b1 || mem_addr !== 32'h0) begin
      n_errors++;
      $display("FAIL reset_c1_req: got req %b addr %h required 1 00000000", mem_req, mem_addr);
    end
    cycle();
    n_checks++;
    if (valid_saida !== 1'b1 || instr_saida !== 32'h0000_2083 || pc_instr !== 32'h0) begin
      n_errors++;
      $display("FAIL reset_c2_out: got valid %b instr %h pc %h required 1 00002083 00000000",
               valid_saida, instr_saida, pc_instr);
    end
    cycle();
    n_checks++;
    if (mem_req !== 1'b1 || mem_addr !== 32'h4) begin
      n_errors++;
      $display("FAIL reset_c3_req: got req %b addr %h required 1 00000004", mem_req, mem_addr);
    end
  endtask

  task automatic test_stall();
    mem_wait = 0;
    do_reset();
    drv_pronto = 1'b0;
    repeat (2) cycle();
    for (int i = 0; i < 5; i++) begin
      cycle();
      n_checks++;
      if (valid_saida !== 1'b1 || mem_req !== 1'b0 || pc_instr !== 32'h0 || instr_saida !== 32'h0000_2083) begin
        n_errors++;
        $display("FAIL stall_hold[%0d]: got valid %b req %b pc %h instr %h required 1 0 00000000 00002083",
                 i, valid_saida, mem_req, pc_instr, instr_saida);
      end
    end
    drv_pronto = 1'b1;
    cycle();
    cycle();
    n_checks++;
    if (mem_req !== 1'b1 || mem_addr !== 32'h4) begin
      n_errors++;
      $display("FAIL stall_next: got req %b addr %h required 1 00000004", mem_req, mem_addr);
    end
  endtask

  task automatic test_redirect_hold();
    mem_wait = 0;
    do_reset();
    repeat (6) cycle();
    drv_desvio = 1'b1;
    drv_alvo   = 32'h40;
    cycle();
    n_checks++;
    if (valid_saida !== 1'b1 || pc_instr !== 32'h8) begin
      n_errors++;
      $display("FAIL hold_pre: got valid %b pc %h required 1 00000008", valid_saida, pc_instr);
    end
    drv_desvio = 1'b0;
    cycle();
    n_checks++;
    if (valid_saida !== 1'b0 || mem_req !== 1'b1 || mem_addr !== 32'h40) begin
      n_errors++;
      $display("FAIL hold_flush: got valid %b req %b addr %h required 0 1 00000040",
               valid_saida, mem_req, mem_addr);
    end
    cycle();
    n_checks++;
    if (valid_saida !== 1'b1 || pc_instr !== 32'h40 || instr_saida !== mem_word(32'h40)) begin
      n_errors++;
      $display("FAIL hold_target: got valid %b pc %h instr %h required 1 00000040 %h",
               valid_saida, pc_instr, instr_saida, mem_word(32'h40));
    end
  endtask

  task automatic test_redirect_wait();
    mem_wait = 3;
    do_reset();
    repeat (5) cycle();
    drv_desvio = 1'b1;
    drv_alvo   = 32'hC;
    cycle();
    n_checks++;
    if (valid_saida !== 1'b1 || pc_instr !== 32'h0) begin
      n_errors++;
      $display("FAIL wait_pre: got valid %b pc %h required 1 00000000", valid_saida, pc_instr);
    end
    for (int i = 0; i < 4; i++) begin
      drv_desvio = (i < 2);
      drv_alvo   = (i == 0) ? 32'h80 : 32'h90;
      cycle();
      n_checks++;
      if (mem_req !== 1'b1 || mem_addr !== 32'hC || valid_saida !== 1'b0) begin
        n_errors++;
        $display("FAIL wait_hold[%0d]: got req %b addr %h valid %b required 1 0000000c 0",
                 i, mem_req, mem_addr, valid_saida);
      end
    end
    drv_desvio = 1'b0;
    cycle();
    n_checks++;
    if (mem_req !== 1'b1 || mem_addr !== 32'h90) begin
      n_errors++;
      $display("FAIL wait_target: got req %b addr %h required 1 00000090", mem_req, mem_addr);
    end
    repeat (3) cycle();
    cycle();
    n_checks++;
    if (valid_saida !== 1'b1 || pc_instr !== 32'h90 || instr_saida !== mem_word(32'h90)) begin
      n_errors++;
      $display("FAIL wait_deliver: got valid %b pc %h instr %h required 1 00000090 %h",
               valid_saida, pc_instr, instr_saida, mem_word(32'h90));
    end
  endtask

  task automatic test_align();
    mem_wait = 0;
    do_reset();
    cycle();
    drv_desvio = 1'b1;
    drv_alvo   = 32'h0000_0103;
    cycle();
    drv_desvio = 1'b0;
    cycle();
    n_checks++;
    if (mem_req !== 1'b1 || mem_addr !== 32'h100 || valid_saida !== 1'b0) begin
      n_errors++;
      $display("FAIL align_req: got req %b addr %h valid %b required 1 00000100 0",
               mem_req, mem_addr, valid_saida);
    end
    cycle();
    n_checks++;
    if (valid_saida !== 1'b1 || pc_instr !== 32'h100) begin
      n_errors++;
      $display("FAIL align_out: got valid %b pc %h required 1 00000100", valid_saida, pc_instr);
    end
  endtask

  task automatic test_wrap();
    mem_wait = 0;
    do_reset();
    cycle();
    n_checks++;
    if (w_mem_req !== 1'b0) begin
      n_errors++;
      $display("FAIL wrap_c0: got req %b required 0", w_mem_req);
    end
    cycle();
    n_checks++;
    if (w_mem_req !== 1'b1 || w_mem_addr !== 32'hFFFF_FFFC) begin
      n_errors++;
      $display("FAIL wrap_first: got req %b addr %h required 1 fffffffc", w_mem_req, w_mem_addr);
    end
    cycle();
    n_checks++;
    if (w_valid !== 1'b1 || w_pc_instr !== 32'hFFFF_FFFC || w_instr !== 32'h0000_0013) begin
      n_errors++;
      $display("FAIL wrap_out: got valid %b pc %h instr %h required 1 fffffffc 00000013",
               w_valid, w_pc_instr, w_instr);
    end
    cycle();
    n_checks++;
    if (w_mem_req !== 1'b1 || w_mem_addr !== 32'h0) begin
      n_errors++;
      $display("FAIL wrap_second: got req %b addr %h required 1 00000000", w_mem_req, w_mem_addr);
    end
  endtask

  task automatic test_back_to_back();
    int nvalid;
    mem_wait = 0;
    do_reset();
    nvalid = 0;
    for (int i = 0; i < 22; i++) begin
      cycle();
      if (valid_saida === 1'b1) nvalid++;
    end
    n_checks++;
    if (nvalid != 10) begin
      n_errors++;
      $display("FAIL b2b_rate: got %0d deliveries required 10", nvalid);
    end
  endtask

  task automatic test_random();
    mem_wait = 1;
    do_reset();
    for (int i = 0; i < 60; i++) begin
      drv_pronto = ($urandom_range(0, 3) != 0);
      drv_desvio = ($urandom_range(0, 7) == 0);
      drv_alvo   = $urandom_range(0, 255);
      cycle();
    end
    drv_desvio = 1'b0;
    drv_pronto = 1'b1;
  endtask

  task automatic test_async_reset();
    mem_wait = 0;
    do_reset();
    repeat (2) cycle();
    drv_desvio = 1'b1;
    drv_alvo   = 32'h200;
    cycle();
    mem_wait   = 3;
    drv_alvo   = 32'h300;
    cycle();
    drv_desvio = 1'b0;
    cycle();
    n_checks++;
    if (mem_req !== 1'b1 || mem_addr !== 32'h200 || instr_saida !== 32'h0000_2083) begin
      n_errors++;
      $display("FAIL async_pre: got req %b addr %h instr %h required 1 00000200 00002083",
               mem_req, mem_addr, instr_saida);
    end
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if (mem_req !== 1'b0 || mem_addr !== 32'h0 || valid_saida !== 1'b0 ||
        instr_saida !== 32'h0 || pc_instr !== 32'h0) begin
      n_errors++;
      $display("FAIL async_now: got req %b addr %h valid %b instr %h pc %h required 0 00000000 0 00000000 00000000",
               mem_req, mem_addr, valid_saida, instr_saida, pc_instr);
    end
    mem_wait = 0;
    do_reset();
    cycle();
    cycle();
    n_checks++;
    if (mem_req !== 1'b1 || mem_addr !== 32'h0) begin
      n_errors++;
      $display("FAIL async_restart: got req %b addr %h required 1 00000000", mem_req, mem_addr);
    end
    cycle();
  endtask

  initial begin
    n_checks     = 0;
    n_errors     = 0;
    rst          = 1'b1;
    mem_ack      = 1'b0;
    mem_rdata    = '0;
    desvio       = 1'b0;
    alvo_desvio  = '0;
    pronto_decod = 1'b1;
    drv_desvio   = 1'b0;
    drv_alvo     = '0;
    drv_pronto   = 1'b1;
    mem_wait     = 0;
    req_act      = 1'b0;
    req_addr     = '0;
    wcnt         = 0;
    poison       = 1'b0;
    test_reset();
    test_stall();
    test_redirect_hold();
    test_redirect_wait();
    test_align();
    test_wrap();
    test_back_to_back();
    test_random();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
